// File: rtl/fifo_rd_stream_nox_if.sv
// Narrow valid/ready beat stream leaving fifo_rd_stream_nox.
//   valid  : beat valid (driven by master)
//   ready  : sink ready (driven by slave)
//   data   : beat data, OUT_WIDTH bits (driven by master)
//   last   : final beat of a FIFO entry, qualified by valid (driven by master)
interface fifo_rd_stream_nox_if #(
  parameter int OUT_WIDTH = 8
);
  logic                 valid;
  logic                 ready;
  logic [OUT_WIDTH-1:0] data;
  logic                 last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fifo_rd_stream_nox.sv
// fifo_rd_stream_nox
// Drains the read side of a show-ahead FIFO and sends each IN_WIDTH entry as
// BEATS = IN_WIDTH/OUT_WIDTH narrow beats on a valid/ready stream.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous reset, active-low
//   clear_i      : synchronous flush of the entry currently being sent
//   fifo_empty_i : FIFO empty flag
//   fifo_data_i  : FIFO head entry (combinational, valid when not empty)
//   fifo_read_o  : FIFO pop strobe (combinational)
//   strm         : beat stream (valid/ready/data/last), master side
module fifo_rd_stream_nox #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    fifo_empty_i,
  input  logic [IN_WIDTH-1:0]     fifo_data_i,
  output logic                    fifo_read_o,
  fifo_rd_stream_nox_if.master    strm
);

  localparam int BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

`ifndef NO_ASSERTIONS
  if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
    $error("fifo_rd_stream_nox: IN_WIDTH must be a multiple of OUT_WIDTH");
  end
  if (BEATS < 2) begin : g_bad_beats
    $error("fifo_rd_stream_nox: IN_WIDTH/OUT_WIDTH must be at least 2");
  end
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [IN_WIDTH-1:0] shift_q, shift_d;

  logic in_send;
  logic is_last;
  logic handshake;

  assign in_send   = (state_q == SEND);
  assign is_last   = in_send && (beat_cnt_q == LAST_BEAT);
  assign handshake = in_send && strm.ready;

  // The entry is shifted after each accepted beat so the current beat always
  // sits at a fixed end of the register; this is equivalent to selecting
  // slice[beat_cnt] without a wide mux.
  assign strm.valid = in_send;
  assign strm.last  = is_last;
  always_comb begin
    strm.data = '0;
    if (in_send) begin
      if (MSB_FIRST) begin
        strm.data = shift_q[IN_WIDTH-1 -: OUT_WIDTH];
      end else begin
        strm.data = shift_q[OUT_WIDTH-1:0];
      end
    end
  end

  // Next-state logic. Pops happen only when the FIFO reports data, never
  // under reset or clear, and a last-beat handshake reloads directly so
  // back-to-back entries stream without a bubble.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    shift_d     = shift_q;
    fifo_read_o = 1'b0;
    if (!rst) begin
      fifo_read_o = 1'b0;
    end else if (clear_i) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
      shift_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty_i) begin
            fifo_read_o = 1'b1;
            shift_d     = fifo_data_i;
            beat_cnt_d  = '0;
            state_d     = SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            if (!is_last) begin
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
              if (MSB_FIRST) begin
                shift_d = shift_q << OUT_WIDTH;
              end else begin
                shift_d = shift_q >> OUT_WIDTH;
              end
            end else if (!fifo_empty_i) begin
              fifo_read_o = 1'b1;
              shift_d     = fifo_data_i;
              beat_cnt_d  = '0;
            end else begin
              state_d    = IDLE;
              beat_cnt_d = '0;
              shift_d    = '0;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          shift_d    = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream_nox.sv
// Testbench for fifo_rd_stream_nox: an LSB-first instance fed by a small
// FIFO model and an MSB-first instance driven directly.
module tb_fifo_rd_stream_nox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clear;
  logic        ready;

  // Small show-ahead FIFO model for the LSB-first instance.
  logic [31:0] fifo_mem [0:7];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_count = 0;
  int          bad_pops = 0;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_read;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = fifo_mem[rd_ptr[2:0]];

  // Pop on the clock edge and record any pop issued against an empty FIFO.
  always @(posedge clk) begin
    if (fifo_read) begin
      if (fifo_empty) begin
        bad_pops <= bad_pops + 1;
      end else begin
        rd_ptr    <= rd_ptr + 1;
        pop_count <= pop_count + 1;
      end
    end
  end

  // MSB-first instance inputs.
  logic        empty_msb;
  logic [31:0] data_msb;
  logic        read_msb;

  fifo_rd_stream_nox_if #(.OUT_WIDTH(8)) strm_lsb ();
  fifo_rd_stream_nox_if #(.OUT_WIDTH(8)) strm_msb ();
  assign strm_lsb.ready = ready;
  assign strm_msb.ready = ready;

  fifo_rd_stream_nox #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_read_o  (fifo_read),
    .strm         (strm_lsb)
  );

  fifo_rd_stream_nox #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear),
    .fifo_empty_i (empty_msb),
    .fifo_data_i  (data_msb),
    .fifo_read_o  (read_msb),
    .strm         (strm_msb)
  );

  int checks = 0;
  int failures = 0;

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic clr);
    ready = rdy;
    clear = clr;
  endtask

  task automatic pushEntry(input logic [31:0] value);
    fifo_mem[wr_ptr[2:0]] = value;
    wr_ptr = wr_ptr + 1;
  endtask

  // Let inputs settle, check the LSB instance, then move to the next cycle.
  task automatic checkLsb(input string tag, input logic v, input logic [7:0] d,
                          input logic l, input logic r);
    #1;
    checkOutput({tag, ".valid"}, {31'd0, strm_lsb.valid}, {31'd0, v});
    checkOutput({tag, ".data"},  {24'd0, strm_lsb.data},  {24'd0, d});
    checkOutput({tag, ".last"},  {31'd0, strm_lsb.last},  {31'd0, l});
    checkOutput({tag, ".read"},  {31'd0, fifo_read},      {31'd0, r});
    @(posedge clk);
    #1;
  endtask

  task automatic checkMsb(input string tag, input logic v, input logic [7:0] d,
                          input logic l, input logic r);
    #1;
    checkOutput({tag, ".valid"}, {31'd0, strm_msb.valid}, {31'd0, v});
    checkOutput({tag, ".data"},  {24'd0, strm_msb.data},  {24'd0, d});
    checkOutput({tag, ".last"},  {31'd0, strm_msb.last},  {31'd0, l});
    checkOutput({tag, ".read"},  {31'd0, read_msb},       {31'd0, r});
    @(posedge clk);
    #1;
  endtask

  int pops_before;

  initial begin
    rst       = 1'b0;
    clear     = 1'b0;
    ready     = 1'b1;
    empty_msb = 1'b1;
    data_msb  = 32'h0;
    pushEntry(32'hAABBCCDD);
    @(posedge clk);
    #1;

    // Reset held with the FIFO non-empty: nothing may come out or be popped.
    for (int i = 0; i < 2; i++) begin
      checkLsb($sformatf("rst%0d", i), 1'b0, 8'h00, 1'b0, 1'b0);
    end
    checkOutput("rst.pops", pop_count, 0);

    // Single entry, LSB first.
    rst = 1'b1;
    checkLsb("one.pop", 1'b0, 8'h00, 1'b0, 1'b1);
    checkLsb("one.b0",  1'b1, 8'hDD, 1'b0, 1'b0);
    checkLsb("one.b1",  1'b1, 8'hCC, 1'b0, 1'b0);
    checkLsb("one.b2",  1'b1, 8'hBB, 1'b0, 1'b0);
    checkLsb("one.b3",  1'b1, 8'hAA, 1'b1, 1'b0);
    checkLsb("one.idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Two queued entries stream back to back; second pop shares beat 03.
    pops_before = pop_count;
    pushEntry(32'h03020100);
    pushEntry(32'h07060504);
    checkLsb("two.pop", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkLsb($sformatf("two.b%0d", i), 1'b1, 8'(i), (i == 3) || (i == 7), (i == 3));
    end
    checkLsb("two.idle", 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("two.pops", pop_count - pops_before, 2);

    // Backpressure at beat 1 holds CC stable for three cycles.
    pushEntry(32'hAABBCCDD);
    checkLsb("bp.pop", 1'b0, 8'h00, 1'b0, 1'b1);
    checkLsb("bp.b0",  1'b1, 8'hDD, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkLsb($sformatf("bp.hold%0d", i), 1'b1, 8'hCC, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0);
    checkLsb("bp.b1",  1'b1, 8'hCC, 1'b0, 1'b0);
    checkLsb("bp.b2",  1'b1, 8'hBB, 1'b0, 1'b0);
    checkLsb("bp.b3",  1'b1, 8'hAA, 1'b1, 1'b0);
    checkLsb("bp.idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Clear while beat 2 is pending; the next entry restarts at beat 0.
    pops_before = pop_count;
    pushEntry(32'h13121110);
    checkLsb("clr.pop", 1'b0, 8'h00, 1'b0, 1'b1);
    checkLsb("clr.b0",  1'b1, 8'h10, 1'b0, 1'b0);
    checkLsb("clr.b1",  1'b1, 8'h11, 1'b0, 1'b0);
    pushEntry(32'h23222120);
    applyStimulus(1'b0, 1'b1);
    checkLsb("clr.cyc", 1'b1, 8'h12, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkLsb("clr.pop2", 1'b0, 8'h00, 1'b0, 1'b1);
    checkLsb("clr.n0",  1'b1, 8'h20, 1'b0, 1'b0);
    checkLsb("clr.n1",  1'b1, 8'h21, 1'b0, 1'b0);
    checkLsb("clr.n2",  1'b1, 8'h22, 1'b0, 1'b0);
    checkLsb("clr.n3",  1'b1, 8'h23, 1'b1, 1'b0);
    checkLsb("clr.idle", 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("clr.pops", pop_count - pops_before, 2);

    // MSB-first instance.
    data_msb  = 32'h11223344;
    empty_msb = 1'b0;
    checkMsb("msb.pop", 1'b0, 8'h00, 1'b0, 1'b1);
    empty_msb = 1'b1;
    checkMsb("msb.b0",  1'b1, 8'h11, 1'b0, 1'b0);
    checkMsb("msb.b1",  1'b1, 8'h22, 1'b0, 1'b0);
    checkMsb("msb.b2",  1'b1, 8'h33, 1'b0, 1'b0);
    checkMsb("msb.b3",  1'b1, 8'h44, 1'b1, 1'b0);
    checkMsb("msb.idle", 1'b0, 8'h00, 1'b0, 1'b0);

    checkOutput("badPops", bad_pops, 0);
    checkOutput("fifoDrained", {31'd0, fifo_empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
